lvc_i2c_target_rsp: RTL

//  RTL I2C target (slave) that answers transfers driven by an I2C controller on the shared wired-AND SCL/SDA bus.

---
 rtl/lvc_i2c_target_rsp.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lvc_i2c_target_rsp.sv
// I2C target responder with a DEPTH x 8 register file behind an
// auto-incrementing byte pointer. The bus is oversampled with CLK; SDA is
// only ever pulled low (open drain) and SCL is never stretched.
module lvc_i2c_target_rsp #(
    parameter logic [6:0] SLAVE_ADDR = 7'h33,
    parameter int         DEPTH      = 16,
    parameter int         HOLD_CYC   = 2,
    localparam int        PW         = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          start_det,
    output logic          stop_det,
    output logic          addr_hit,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_e;

    // Synchronizer and previous-value stages; reset to the idle (high) bus level
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    state_e        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          pend_oe_q, pend_oe_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          busy_q, busy_d;
    logic          start_det_q, stop_det_q;
    logic          addr_hit_q, addr_hit_d;
    logic          wr_en_q, wr_en_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    mem_q [DEPTH];

    logic          scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]    shift_in;
    logic [7:0]    rd_byte;
    logic          mem_we;
    logic          sched;
    logic          sched_val;

    // Bring the asynchronous bus lines into the CLK domain
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise = scl_sync_q & ~scl_prev_q;
    assign scl_fall = ~scl_sync_q & scl_prev_q;
    assign start_c  = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_c   = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    assign shift_in = {shift_q[6:0], sda_sync_q};
    assign rd_byte  = mem_q[ptr_q];

    // Next-state, bit handling and SDA scheduling for the transfer FSM
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        pend_oe_d  = pend_oe_q;
        hold_cnt_d = hold_cnt_q;
        busy_d     = busy_q;
        addr_hit_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        sched      = 1'b0;
        sched_val  = 1'b0;

        // A scheduled SDA change lands HOLD_CYC cycles after the SCL fall
        if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
            if (hold_cnt_q == HW'(1)) sda_oe_d = pend_oe_q;
        end

        if (start_c) begin
            state_d    = ST_ADDR;
            bitcnt_d   = 4'd0;
            sda_oe_d   = 1'b0;
            hold_cnt_d = '0;
            busy_d     = 1'b1;
        end else if (stop_c) begin
            state_d    = ST_IDLE;
            bitcnt_d   = 4'd0;
            sda_oe_d   = 1'b0;
            hold_cnt_d = '0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (state_q == ST_ADDR) begin
                                addr_hit_d = (shift_in[7:1] == SLAVE_ADDR);
                            end else if (state_q == ST_PTR) begin
                                ptr_d = shift_in[PW-1:0];
                            end else begin
                                mem_we    = 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = shift_in;
                                ptr_d     = ptr_q + PW'(1);
                            end
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        // End of the 8th bit: open the ACK slot or drop out
                        if (state_q == ST_ADDR && shift_q[7:1] != SLAVE_ADDR) begin
                            state_d = ST_IGNORE;
                        end else begin
                            sched     = 1'b1;
                            sched_val = 1'b1;
                            if (state_q == ST_ADDR)     state_d = ST_ADDR_ACK;
                            else if (state_q == ST_PTR) state_d = ST_PTR_ACK;
                            else                        state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        sched    = 1'b1;
                        if (shift_q[0]) begin
                            tx_d      = rd_byte;
                            sched_val = ~rd_byte[7];
                            state_d   = ST_RDATA;
                        end else begin
                            state_d = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        sched    = 1'b1;
                        state_d  = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        sched   = 1'b1;
                        ptr_d   = ptr_q + PW'(1);
                        state_d = ST_RACK;
                    end else if (scl_fall && bitcnt_q != 4'd0) begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        sched     = 1'b1;
                        sched_val = ~tx_q[6];
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                    end else if (scl_fall) begin
                        sched = 1'b1;
                        if (!shift_q[0]) begin
                            tx_d      = rd_byte;
                            sched_val = ~rd_byte[7];
                            bitcnt_d  = 4'd0;
                            state_d   = ST_RDATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (sched) begin
            pend_oe_d  = sched_val;
            hold_cnt_d = HW'(HOLD_CYC);
        end
    end

    // Transfer state, pointer and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            pend_oe_q   <= 1'b0;
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            pend_oe_q   <= pend_oe_d;
            hold_cnt_q  <= hold_cnt_d;
            busy_q      <= busy_d;
            start_det_q <= start_c;
            stop_det_q  <= stop_c;
            addr_hit_q  <= addr_hit_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file storage, written on the 8th SCL rise of each data byte
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the register file is reset on purpose; its all-zero power-on content is architecturally visible.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (mem_we) begin
            mem_q[ptr_q] <= shift_in;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign addr_hit  = addr_hit_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
